// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: FSM state encodings, default oversampling
// factor and the standard stop-period lengths in TICK units.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam int NUM_TICKS_DEF = 16;

  // Stop-period lengths for 16x oversampling: 1, 1.5 and 2 stop bits.
  localparam int SB_1   = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2   = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: frames a parallel word as start / data (LSB first) /
// optional parity / stop on tx, paced by a 16x oversampled tick strobe.
//
// Handshake: tx_start is a level request. It is accepted on any clk edge
// where the FSM is idle (tx_busy low); acceptance is signalled by tx_busy
// rising on that same edge. Requests while tx_busy is high are dropped,
// not queued. tx_done pulses for one cycle on the edge that ends the stop
// period, together with tx_busy falling.
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int DBIT       = 8,
  parameter int NUM_TICKS  = NUM_TICKS_DEF,
  parameter int SB_TICK    = SB_1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tick,
  input  logic            tx_start,
  input  logic [DBIT-1:0] din,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done,
  output logic [2:0]      state_dbg
);

  localparam int TW = $clog2(max_int(NUM_TICKS, SB_TICK));
  localparam int BW = $clog2(DBIT);

  localparam logic [TW-1:0] TICK_LAST = TW'(NUM_TICKS - 1);
  localparam logic [TW-1:0] STOP_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DBIT - 1);

  uart_state_e     state, state_n;
  logic [TW-1:0]   tick_cnt, tick_cnt_n;
  logic [BW-1:0]   bit_cnt, bit_cnt_n;
  logic [DBIT-1:0] shift, shift_n;
  logic            parity, parity_n;
  logic            tx_n, busy_n, done_n;

  assign state_dbg = state;

  // State, counters, shift register and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      parity   <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      parity   <= parity_n;
      tx       <= tx_n;
      tx_busy  <= busy_n;
      tx_done  <= done_n;
    end
  end

  // Next-state and next-output logic; tx is computed here so the line
  // register never glitches on a state decode.
  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    shift_n    = shift;
    parity_n   = parity;
    tx_n       = tx;
    busy_n     = tx_busy;
    done_n     = 1'b0;
    case (state)
      ST_IDLE: begin
        tx_n = 1'b1;
        // Accept does not wait for tick; a coincident tick is not counted.
        if (tx_start) begin
          shift_n    = din;
          parity_n   = (PARITY_ODD != 0) ? ~^din : ^din;
          tick_cnt_n = '0;
          bit_cnt_n  = '0;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
          state_n    = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            tx_n       = shift[0];
            state_n    = ST_DATA;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            shift_n    = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              if (PARITY_EN != 0) begin
                tx_n    = parity;
                state_n = ST_PARITY;
              end else begin
                tx_n    = 1'b1;
                state_n = ST_STOP;
              end
            end else begin
              bit_cnt_n = bit_cnt + 1'b1;
              tx_n      = shift[1];
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            tx_n       = 1'b1;
            state_n    = ST_STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_STOP: begin
        tx_n = 1'b1;
        if (tick) begin
          if (tick_cnt == STOP_LAST) begin
            tick_cnt_n = '0;
            done_n     = 1'b1;
            busy_n     = 1'b0;
            state_n    = ST_IDLE;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      default: begin
        tx_n    = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
